// File: rtl/pdp8l_tty_sequencer.sv
// Hardware servicing of the PDP-8/L teletype register port: keyboard FIFO feeds
// register 1, register 2 printer output drains into a FIFO, both paced per character.
module pdp8l_tty_sequencer #(
  parameter int          KBLOG2    = 4,
  parameter int          PRLOG2    = 4,
  parameter logic [23:0] CHARTICKS = 24'd10000000
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              enable,
  input  logic              kbin_valid,
  input  logic [7:0]        kbin_data,
  output logic              kbin_ready,
  output logic              prout_valid,
  output logic [7:0]        prout_data,
  input  logic              prout_ready,
  output logic [KBLOG2:0]   kb_count,
  output logic [PRLOG2:0]   pr_count,
  output logic              tty_armwrite,
  output logic [1:0]        tty_armwaddr,
  output logic [1:0]        tty_armraddr,
  output logic [31:0]       tty_armwdata,
  input  logic [31:0]       tty_armrdata
);

  localparam int KBDEPTH = 1 << KBLOG2;
  localparam int PRDEPTH = 1 << PRLOG2;
  localparam int KBW     = KBLOG2 + 1;
  localparam int PRW     = PRLOG2 + 1;

  typedef enum logic [1:0] {RDKB = 2'd0, EVKB = 2'd1, RDPR = 2'd2, EVPR = 2'd3} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_kbmem [0:KBDEPTH-1];
  logic [7:0]    r_prmem [0:PRDEPTH-1];
  logic [KBW-1:0] r_kbwptr, r_kbrptr;
  logic [PRW-1:0] r_prwptr, r_prrptr;
  logic [23:0]   r_kbtmr, r_prtmr;
  logic [31:0]   r_rdata;
  logic          r_armwrite;
  logic [1:0]    r_armwaddr, r_armraddr;
  logic [31:0]   r_armwdata;

  logic          w_kbpush, w_kbpop, w_kbempty;
  logic          w_prpush, w_prpop, w_prfull;
  logic          w_kbload, w_prload;
  logic [7:0]    w_kbhead;
  logic          w_write_nxt;
  logic [1:0]    w_waddr_nxt, w_raddr_nxt;
  logic [31:0]   w_wdata_nxt;

  // Occupancy is the pointer difference; the extra MSB distinguishes full from empty.
  assign kb_count    = r_kbwptr - r_kbrptr;
  assign pr_count    = r_prwptr - r_prrptr;
  assign w_kbempty   = (kb_count == '0);
  assign kbin_ready  = ~kb_count[KBLOG2];
  assign w_prfull    = pr_count[PRLOG2];
  assign prout_valid = (pr_count != '0);
  assign w_kbhead    = r_kbmem[r_kbrptr[KBLOG2-1:0]];
  assign prout_data  = r_prmem[r_prrptr[PRLOG2-1:0]];
  assign w_kbpush    = kbin_valid & kbin_ready;
  assign w_prpop     = prout_valid & prout_ready;

  assign tty_armwrite = r_armwrite;
  assign tty_armwaddr = r_armwaddr;
  assign tty_armraddr = r_armraddr;
  assign tty_armwdata = r_armwdata;

  // FIFO storage arrays (no reset needed, pointers define validity)
  always_ff @(posedge CLOCK) begin
    if (w_kbpush) r_kbmem[r_kbwptr[KBLOG2-1:0]] <= kbin_data;
    if (w_prpush) r_prmem[r_prwptr[PRLOG2-1:0]] <= r_rdata[7:0];
  end

  // FIFO pointers
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_kbwptr <= '0;
      r_kbrptr <= '0;
      r_prwptr <= '0;
      r_prrptr <= '0;
    end else begin
      if (w_kbpush) r_kbwptr <= r_kbwptr + KBW'(1);
      if (w_kbpop)  r_kbrptr <= r_kbrptr + KBW'(1);
      if (w_prpush) r_prwptr <= r_prwptr + PRW'(1);
      if (w_prpop)  r_prrptr <= r_prrptr + PRW'(1);
    end
  end

  // Pacing timers: reload on each delivered/completed character, count down to zero
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_kbtmr <= 24'd0;
      r_prtmr <= 24'd0;
    end else begin
      if (w_kbload)            r_kbtmr <= CHARTICKS;
      else if (r_kbtmr != 24'd0) r_kbtmr <= r_kbtmr - 24'd1;
      else                     r_kbtmr <= r_kbtmr;
      if (w_prload)            r_prtmr <= CHARTICKS;
      else if (r_prtmr != 24'd0) r_prtmr <= r_prtmr - 24'd1;
      else                     r_prtmr <= r_prtmr;
    end
  end

  // State, read-data capture and registered register-port outputs
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state    <= RDKB;
      r_rdata    <= 32'd0;
      r_armwrite <= 1'b0;
      r_armwaddr <= 2'd0;
      r_armraddr <= 2'd1;
      r_armwdata <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_rdata    <= tty_armrdata;
      r_armwrite <= w_write_nxt;
      r_armwaddr <= w_waddr_nxt;
      r_armraddr <= w_raddr_nxt;
      r_armwdata <= w_wdata_nxt;
    end
  end

  // Round-robin sequencing; EV states act on the register value captured during RD
  always_comb begin
    w_state_nxt = r_state;
    w_write_nxt = 1'b0;
    w_waddr_nxt = r_armwaddr;
    w_wdata_nxt = r_armwdata;
    w_raddr_nxt = r_armraddr;
    w_kbpop     = 1'b0;
    w_prpush    = 1'b0;
    w_kbload    = 1'b0;
    w_prload    = 1'b0;
    case (r_state)
      RDKB: begin
        w_state_nxt = EVKB;
        w_raddr_nxt = 2'd1;
      end
      EVKB: begin
        w_state_nxt = RDPR;
        w_raddr_nxt = 2'd2;
        // kbflag clear means the CPU cannot race this write
        if (!r_rdata[31] && !w_kbempty && (r_kbtmr == 24'd0)) begin
          w_write_nxt = 1'b1;
          w_waddr_nxt = 2'd1;
          w_wdata_nxt = {1'b1, enable, 22'd0, w_kbhead};
          w_kbpop     = 1'b1;
          w_kbload    = 1'b1;
        end else if (!r_rdata[31] && (r_rdata[30] != enable)) begin
          w_write_nxt = 1'b1;
          w_waddr_nxt = 2'd1;
          w_wdata_nxt = {1'b0, enable, 30'd0};
        end else begin
          w_write_nxt = 1'b0;
        end
      end
      RDPR: begin
        w_state_nxt = EVPR;
        w_raddr_nxt = 2'd2;
      end
      EVPR: begin
        w_state_nxt = RDKB;
        w_raddr_nxt = 2'd1;
        // A full printer FIFO leaves prfull set, stalling the PDP-8/L printer
        if (r_rdata[30] && !w_prfull && (r_prtmr == 24'd0)) begin
          w_write_nxt = 1'b1;
          w_waddr_nxt = 2'd2;
          w_wdata_nxt = 32'h8000_0000;
          w_prpush    = 1'b1;
          w_prload    = 1'b1;
        end else begin
          w_write_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = RDKB;
        w_raddr_nxt = 2'd1;
      end
    endcase
  end

endmodule

// File: tb/tb_pdp8l_tty_sequencer.sv
// Bench for pdp8l_tty_sequencer: behavioural TTY register model, vector table,
// and scoreboard queues of expected register writes and printer characters.
module tb_pdp8l_tty_sequencer;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        enable;
  logic        kbin_valid;
  logic [7:0]  kbin_data;
  logic        kbin_ready;
  logic        prout_valid;
  logic [7:0]  prout_data;
  logic        prout_ready;
  logic [4:0]  kb_count;
  logic [4:0]  pr_count;
  logic        tty_armwrite;
  logic [1:0]  tty_armwaddr;
  logic [1:0]  tty_armraddr;
  logic [31:0] tty_armwdata;
  logic [31:0] tty_armrdata;

  logic [31:0] m_reg1, m_reg2;
  logic        auto_clr;
  logic        kb_seen;
  int          cyc;
  int          n_pass, n_total;
  logic [31:0] kb_q[$];
  logic [31:0] pr_q[$];
  logic [7:0]  prc_q[$];
  int          kbw_times[$];

  typedef struct {
    logic        en;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic        push;
    logic [7:0]  ch;
    logic        kbw;
    logic [31:0] kbd;
    logic        prw;
    logic [7:0]  prc;
  } vec_t;

  vec_t vecs[10];

  pdp8l_tty_sequencer #(.KBLOG2(4), .PRLOG2(4), .CHARTICKS(24'd8)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .enable(enable),
    .kbin_valid(kbin_valid), .kbin_data(kbin_data), .kbin_ready(kbin_ready),
    .prout_valid(prout_valid), .prout_data(prout_data), .prout_ready(prout_ready),
    .kb_count(kb_count), .pr_count(pr_count),
    .tty_armwrite(tty_armwrite), .tty_armwaddr(tty_armwaddr),
    .tty_armraddr(tty_armraddr), .tty_armwdata(tty_armwdata),
    .tty_armrdata(tty_armrdata)
  );

  always #5 CLOCK = ~CLOCK;

  assign tty_armrdata = (tty_armraddr == 2'd1) ? m_reg1 :
                        (tty_armraddr == 2'd2) ? m_reg2 : 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Advance one clock, sample at the falling edge, check and apply any register write.
  task automatic step();
    @(negedge CLOCK);
    cyc++;
    if (!RESET && tty_armwrite) begin
      if (tty_armwaddr == 2'd1) begin
        kb_seen = 1'b1;
        kbw_times.push_back(cyc);
        if (kb_q.size() == 0) begin
          n_total++;
          $display("FAIL unexp_kb_write: got wdata %h expected no write", tty_armwdata);
        end else begin
          chk("kb_write_data", tty_armwdata, kb_q.pop_front());
        end
        m_reg1 = tty_armwdata;
        if (auto_clr) m_reg1[31] = 1'b0;
      end else if (tty_armwaddr == 2'd2) begin
        if (pr_q.size() == 0) begin
          n_total++;
          $display("FAIL unexp_pr_write: got wdata %h expected no write", tty_armwdata);
        end else begin
          chk("pr_write_data", tty_armwdata, pr_q.pop_front());
        end
        m_reg2 = tty_armwdata;
      end else begin
        chk("waddr_range", {30'd0, tty_armwaddr}, 32'd1);
      end
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0; cyc = 0;
    RESET = 1'b1; enable = 1'b1; kbin_valid = 1'b0; kbin_data = 8'd0;
    prout_ready = 1'b0; auto_clr = 1'b1; kb_seen = 1'b0;
    m_reg1 = 32'h4000_0000; m_reg2 = 32'h0000_0000;

    vecs[0] = '{1'b1, 32'h4000_0000, 32'h0, 1'b1, 8'h41, 1'b1, 32'hC000_0041, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 32'h4000_0000, 32'h0, 1'b1, 8'h7F, 1'b1, 32'hC000_007F, 1'b0, 8'h00};
    vecs[2] = '{1'b0, 32'h0000_0000, 32'h0, 1'b1, 8'h30, 1'b1, 32'h8000_0030, 1'b0, 8'h00};
    vecs[3] = '{1'b1, 32'h0000_0000, 32'h0, 1'b0, 8'h00, 1'b1, 32'h4000_0000, 1'b0, 8'h00};
    vecs[4] = '{1'b0, 32'h4000_0000, 32'h0, 1'b0, 8'h00, 1'b1, 32'h0000_0000, 1'b0, 8'h00};
    vecs[5] = '{1'b0, 32'hC000_0000, 32'h0, 1'b0, 8'h00, 1'b0, 32'h0000_0000, 1'b0, 8'h00};
    vecs[6] = '{1'b1, 32'h4000_0000, 32'h4000_000D, 1'b0, 8'h00, 1'b0, 32'h0, 1'b1, 8'h0D};
    vecs[7] = '{1'b1, 32'h4000_0000, 32'h4000_0061, 1'b0, 8'h00, 1'b0, 32'h0, 1'b1, 8'h61};
    vecs[8] = '{1'b1, 32'h4000_0042, 32'h0000_0055, 1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 8'h00};
    vecs[9] = '{1'b1, 32'h4000_0000, 32'h4000_000A, 1'b1, 8'h5A, 1'b1, 32'hC000_005A, 1'b1, 8'h0A};

    repeat (3) @(negedge CLOCK);
    chk("rst_kbin_ready",  {31'd0, kbin_ready},   32'd1);
    chk("rst_prout_valid", {31'd0, prout_valid},  32'd0);
    chk("rst_armwrite",    {31'd0, tty_armwrite}, 32'd0);
    chk("rst_waddr",       {30'd0, tty_armwaddr}, 32'd0);
    chk("rst_wdata",       tty_armwdata,          32'd0);
    chk("rst_raddr",       {30'd0, tty_armraddr}, 32'd1);
    chk("rst_kb_count",    {27'd0, kb_count},     32'd0);
    chk("rst_pr_count",    {27'd0, pr_count},     32'd0);
    RESET = 1'b0;
    repeat (8) step();

    // Vector table
    for (int i = 0; i < 10; i++) begin
      m_reg1 = vecs[i].reg1;
      m_reg2 = vecs[i].reg2;
      enable = vecs[i].en;
      if (vecs[i].kbw) kb_q.push_back(vecs[i].kbd);
      if (vecs[i].prw) begin
        pr_q.push_back(32'h8000_0000);
        prc_q.push_back(vecs[i].prc);
      end
      if (vecs[i].push) begin
        kbin_valid = 1'b1; kbin_data = vecs[i].ch;
        step();
        kbin_valid = 1'b0;
      end
      repeat (16) step();
      chk($sformatf("v%0d_kb_pending", i), kb_q.size(), 32'd0);
      chk($sformatf("v%0d_pr_pending", i), pr_q.size(), 32'd0);
      chk($sformatf("v%0d_kb_count", i), {27'd0, kb_count}, 32'd0);
      if (vecs[i].prw) begin
        chk($sformatf("v%0d_prout_valid", i), {31'd0, prout_valid}, 32'd1);
        chk($sformatf("v%0d_prout_data", i), {24'd0, prout_data}, {24'd0, prc_q.pop_front()});
        prout_ready = 1'b1;
        step();
        prout_ready = 1'b0;
      end
      chk($sformatf("v%0d_pr_count", i), {27'd0, pr_count}, 32'd0);
    end

    // kbflag held by the CPU: nothing delivered until it clears
    auto_clr = 1'b0; enable = 1'b1; m_reg1 = 32'hC000_0000;
    kbin_valid = 1'b1; kbin_data = 8'h41; step();
    kbin_data = 8'h42; step();
    kbin_valid = 1'b0;
    repeat (16) step();
    chk("hold_kb_count2", {27'd0, kb_count}, 32'd2);
    kb_q.push_back(32'hC000_0041);
    m_reg1[31] = 1'b0;
    repeat (16) step();
    chk("hold_first_seen", kb_q.size(), 32'd0);
    chk("hold_kb_count1", {27'd0, kb_count}, 32'd1);
    kb_q.push_back(32'hC000_0042);
    m_reg1[31] = 1'b0;
    repeat (16) step();
    chk("hold_second_seen", kb_q.size(), 32'd0);
    chk("hold_kb_count0", {27'd0, kb_count}, 32'd0);
    auto_clr = 1'b1; m_reg1[31] = 1'b0;

    // Pacing: three back-to-back characters, instant consumption
    kbw_times.delete();
    for (int k = 0; k < 3; k++) begin
      kb_q.push_back(32'hC000_0061 + k);
      kbin_valid = 1'b1; kbin_data = 8'h61 + 8'(k);
      step();
    end
    kbin_valid = 1'b0;
    repeat (60) step();
    chk("pace_all_seen", kb_q.size(), 32'd0);
    chk("pace_nwrites", kbw_times.size(), 32'd3);
    if (kbw_times.size() == 3) begin
      chk("pace_gap1", {31'd0, (kbw_times[1] - kbw_times[0]) >= 8}, 32'd1);
      chk("pace_gap2", {31'd0, (kbw_times[2] - kbw_times[1]) >= 8}, 32'd1);
    end

    // Fill the printer FIFO, then a full FIFO must stall the printer
    prout_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      m_reg2 = 32'h4000_0010 + k;
      pr_q.push_back(32'h8000_0000);
      prc_q.push_back(8'h10 + 8'(k));
      for (int j = 0; j < 40 && m_reg2[30]; j++) step();
      chk($sformatf("fill_write%0d", k), {31'd0, m_reg2[30]}, 32'd0);
    end
    chk("fill_pr_count16", {27'd0, pr_count}, 32'd16);
    m_reg2 = 32'h4000_00AA;
    repeat (20) step();
    chk("full_stall", {31'd0, m_reg2[30]}, 32'd1);
    chk("full_pr_count", {27'd0, pr_count}, 32'd16);
    pr_q.push_back(32'h8000_0000);
    chk("full_head", {24'd0, prout_data}, {24'd0, prc_q.pop_front()});
    prout_ready = 1'b1;
    step();
    prout_ready = 1'b0;
    prc_q.push_back(8'hAA);
    repeat (5) step();
    chk("unstall_write", pr_q.size(), 32'd0);
    chk("unstall_pr_count", {27'd0, pr_count}, 32'd16);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain%0d", k), {24'd0, prout_data}, {24'd0, prc_q.pop_front()});
      prout_ready = 1'b1;
      step();
    end
    prout_ready = 1'b0;
    chk("drain_pr_count", {27'd0, pr_count}, 32'd0);

    // Enable update, then reset during EVKB aborts a pending write
    enable = 1'b1; m_reg1 = 32'h0000_0000; kb_seen = 1'b0;
    kb_q.push_back(32'h4000_0000);
    for (int j = 0; j < 20 && !kb_seen; j++) step();
    chk("en_write_seen", {31'd0, kb_seen}, 32'd1);
    if (kb_seen) begin
      enable = 1'b0;
      kbin_valid = 1'b1; kbin_data = 8'h77;
      step();
      kbin_valid = 1'b0;
      step();
      step();
      RESET = 1'b1;
      #1;
      chk("rst_mid_write", {31'd0, tty_armwrite}, 32'd0);
      chk("rst_mid_raddr", {30'd0, tty_armraddr}, 32'd1);
      step();
      step();
      chk("rst_mid_nowrite", {31'd0, tty_armwrite}, 32'd0);
      RESET = 1'b0;
      chk("rst_rel_kb_count", {27'd0, kb_count}, 32'd0);
      chk("rst_rel_kbin_ready", {31'd0, kbin_ready}, 32'd1);
      kb_q.push_back(32'h0000_0000);
      repeat (16) step();
      chk("rst_rel_enable_write", kb_q.size(), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
